// File: rtl/spi_slave_responder.sv
// SPI mode-0 (MSB first) slave: synchronised SPI inputs, TX holding register, RX word strobe.
// Define SPI_SLAVE_ERR_EN to build the sticky err_overrun / err_frame flags.

module spi_slave_responder #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned SYNC_FLOPS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_ss_n,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  err_overrun,
    output logic                  err_frame,
    input  logic                  err_clear
);

    localparam int unsigned CntW = $clog2(WORD_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and edge history
    // ------------------------------------------------------------------
    logic [SYNC_FLOPS-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_FLOPS-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_FLOPS-1:0] ss_sync_q, ss_sync_d;
    logic                  sclk_hist_q, sclk_hist_d;
    logic                  mosi_hist_q, mosi_hist_d;
    logic                  ss_hist_q, ss_hist_d;

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    always_comb begin
        sclk_sync_d[0] = spi_sclk;
        mosi_sync_d[0] = spi_mosi;
        ss_sync_d[0]   = spi_ss_n;
        for (int i = 1; i < int'(SYNC_FLOPS); i++) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            mosi_sync_d[i] = mosi_sync_q[i-1];
            ss_sync_d[i]   = ss_sync_q[i-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_FLOPS-1];
    assign mosi_s      = mosi_sync_q[SYNC_FLOPS-1];
    assign ss_s        = ss_sync_q[SYNC_FLOPS-1];
    assign sclk_hist_d = sclk_s;
    assign mosi_hist_d = mosi_s;
    assign ss_hist_d   = ss_s;

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;
    assign ss_fall   = ~ss_s & ss_hist_q;

    // ------------------------------------------------------------------
    // Frame FSM, shift registers and TX holding register
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-2:0] rx_shift_q, rx_shift_d;
    logic [WORD_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WORD_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  tx_full_q, tx_full_d;
    logic [WORD_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [WORD_WIDTH-1:0] rx_word;
    logic                  load_tx;
    logic                  frame_err;
    logic                  tx_underrun;

    assign rx_word = {rx_shift_q, mosi_hist_q};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        load_tx    = 1'b0;
        frame_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d    = StShift;
                    load_tx    = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end
            end
            StShift: begin
                if (ss_rise) begin
                    state_d    = StIdle;
                    frame_err  = (bit_cnt_q != '0);
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[WORD_WIDTH-2:0];
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        load_tx    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall && bit_cnt_q != '0) begin
                    // The fall after a word's last rise keeps the freshly loaded MSB.
                    tx_shift_d = {tx_shift_q[WORD_WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_tx) begin
            tx_shift_d = tx_full_q ? tx_hold_q : '0;
            tx_full_d  = 1'b0;
        end
        // Acceptance looks at the pre-load state, so a coincident load lands after the transfer.
        if (tx_load && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
    end

    assign tx_underrun = load_tx & ~tx_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_hist_q <= 1'b0;
            mosi_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_hold_q   <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sclk_hist_q <= sclk_hist_d;
            mosi_hist_q <= mosi_hist_d;
            ss_hist_q   <= ss_hist_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign spi_miso_oe = (state_q == StShift);
    assign spi_miso    = spi_miso_oe & tx_shift_q[WORD_WIDTH-1];
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~tx_full_q;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef SPI_SLAVE_ERR_EN
    logic err_overrun_q, err_overrun_d;
    logic err_frame_q, err_frame_d;

    always_comb begin
        err_overrun_d = err_clear ? 1'b0 : err_overrun_q;
        err_frame_d   = err_clear ? 1'b0 : err_frame_q;
        if (tx_underrun) begin
            err_overrun_d = 1'b1;
        end
        if (frame_err) begin
            err_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_overrun_q <= 1'b0;
            err_frame_q   <= 1'b0;
        end else begin
            err_overrun_q <= err_overrun_d;
            err_frame_q   <= err_frame_d;
        end
    end

    assign err_overrun = err_overrun_q;
    assign err_frame   = err_frame_q;
`else
    logic [2:0] unused_err;

    assign unused_err  = {err_clear, frame_err, tx_underrun};
    assign err_overrun = 1'b0;
    assign err_frame   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_responder.sv
// Scoreboard bench for spi_slave_responder: an SPI master model drives frames, a word-level
// reference model predicts MISO words, RX words and error flags.

module tb_spi_slave_responder;

    localparam int W    = 16;
    localparam int Half = 8;

`ifdef SPI_SLAVE_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_ss_n;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [W-1:0]  tx_data;
    logic          tx_load;
    logic          tx_ready;
    logic          err_overrun;
    logic          err_frame;
    logic          err_clear;

    always #5 clk = ~clk;

    spi_slave_responder #(
        .WORD_WIDTH(W),
        .SYNC_FLOPS(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_ss_n   (spi_ss_n),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .err_overrun(err_overrun),
        .err_frame  (err_frame),
        .err_clear  (err_clear)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] rx_q[$];
    logic [W-1:0] mon_exp;

    // Reference model: holding register, word due on MISO, sticky flags.
    bit           m_full = 1'b0;
    logic [W-1:0] m_hold = '0;
    logic [W-1:0] m_cur  = '0;
    bit           m_ovr  = 1'b0;
    bit           m_frm  = 1'b0;

    int           f_nwords;
    int           f_last_bits;
    logic [W-1:0] f_words[4];
    bit           f_ld[4];
    logic [W-1:0] f_ldw[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_load();
        if (!m_full) m_ovr = 1'b1;
        m_cur  = m_full ? m_hold : '0;
        m_full = 1'b0;
    endtask

    task automatic do_tx_load(input logic [W-1:0] d);
        check("tx_ready", tx_ready, !m_full);
        tx_data = d;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = d;
        end
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        wait_clk(1);
        err_clear = 1'b0;
        m_ovr = 1'b0;
        m_frm = 1'b0;
        wait_clk(1);
        check("err_overrun_cleared", err_overrun, 1'b0);
        check("err_frame_cleared", err_frame, 1'b0);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nb, input bit ld,
                             input logic [W-1:0] ldw, output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < nb; i++) begin
            spi_mosi = w[W-1-i];
            wait_clk(Half);
            got[W-1-i] = spi_miso;
            if (i == 0) check("miso_oe_active", spi_miso_oe, 1'b1);
            if (nb == W && i == W - 1) rx_q.push_back(w);
            spi_sclk = 1'b1;
            wait_clk(Half);
            spi_sclk = 1'b0;
            if (ld && i == 4) do_tx_load(ldw);
        end
    endtask

    task automatic run_frame();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        int           nb;
        nb = W;
        spi_ss_n = 1'b0;
        wait_clk(Half);
        model_load();
        for (int k = 0; k < f_nwords; k++) begin
            nb  = (k == f_nwords - 1) ? f_last_bits : W;
            exp = m_cur;
            send_bits(f_words[k], nb, f_ld[k], f_ldw[k], got);
            if (nb == W) begin
                check("miso_word", got, exp);
                model_load();
            end
        end
        wait_clk(Half);
        spi_ss_n = 1'b1;
        if (nb != W) m_frm = 1'b1;
        wait_clk(Half);
        check("rx_pending", rx_q.size(), 0);
        check("miso_oe_idle", spi_miso_oe, 1'b0);
        check("miso_idle", spi_miso, 1'b0);
        check("err_frame", err_frame, ErrEn & m_frm);
        check("err_overrun", err_overrun, ErrEn & m_ovr);
    endtask

    task automatic set_frame(input int nw, input int last_bits);
        f_nwords    = nw;
        f_last_bits = last_bits;
        for (int k = 0; k < 4; k++) begin
            f_words[k] = '0;
            f_ld[k]    = 1'b0;
            f_ldw[k]   = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_rx_data"}, rx_data, 16'h0000);
        check({tag, "_miso"}, spi_miso, 1'b0);
        check({tag, "_miso_oe"}, spi_miso_oe, 1'b0);
        check({tag, "_tx_ready"}, tx_ready, 1'b1);
        check({tag, "_err_overrun"}, err_overrun, 1'b0);
        check({tag, "_err_frame"}, err_frame, 1'b0);
    endtask

    // Monitor: every rx_valid pulse must match the oldest predicted word.
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            if (rx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_valid_unexpected: got %0h, expected no word", rx_data);
            end else begin
                mon_exp = rx_q.pop_front();
                check("rx_data", rx_data, mon_exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] got;
        reset_n   = 1'b0;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        spi_ss_n  = 1'b1;
        tx_data   = '0;
        tx_load   = 1'b0;
        err_clear = 1'b0;
        wait_clk(3);
        check_reset_outputs("por");
        reset_n = 1'b1;
        wait_clk(4);

        // Single word with a preloaded reply.
        do_tx_load(16'hA55A);
        set_frame(1, W);
        f_words[0] = 16'h1234;
        run_frame();

        // Two words in one frame, second reply loaded during the first word.
        do_tx_load(16'hA55A);
        set_frame(2, W);
        f_words[0] = 16'h0001;
        f_words[1] = 16'hFFFF;
        f_ld[0]    = 1'b1;
        f_ldw[0]   = 16'h00FF;
        run_frame();

        // Aborted frame after 7 bits, then a clean frame.
        clear_errs();
        set_frame(1, 7);
        f_words[0] = 16'h5A5A;
        run_frame();
        set_frame(1, W);
        f_words[0] = 16'hBEEF;
        run_frame();

        // No reply loaded: zeros on MISO.
        clear_errs();
        set_frame(1, W);
        f_words[0] = 16'h7E81;
        run_frame();

        // Reset in the middle of a word.
        do_tx_load(16'h3C3C);
        spi_ss_n = 1'b0;
        wait_clk(Half);
        model_load();
        send_bits(16'h9999, 9, 1'b0, '0, got);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_full = 1'b0;
        m_ovr  = 1'b0;
        m_frm  = 1'b0;
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        set_frame(1, W);
        f_words[0] = 16'hC3C3;
        run_frame();

        // A second load while the holding register is full is ignored.
        do_tx_load(16'h5A5A);
        do_tx_load(16'h1111);
        set_frame(1, W);
        f_words[0] = 16'h2468;
        run_frame();

        // Randomised frames.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) clear_errs();
            if ($urandom_range(0, 1) == 1) do_tx_load(16'($urandom));
            set_frame(int'($urandom_range(1, 3)), W);
            if ($urandom_range(0, 3) == 0) f_last_bits = int'($urandom_range(1, 15));
            for (int k = 0; k < f_nwords; k++) begin
                f_words[k] = 16'($urandom);
                f_ld[k]    = ($urandom_range(0, 1) == 1);
                f_ldw[k]   = 16'($urandom);
            end
            run_frame();
        end

        wait_clk(4);
        check("rx_final_pending", rx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
